// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-receiver bus between the line/baud side and the byte consumer.
//   Tick     oversample enable from the baud generator (one Clk wide)
//   Rx       asynchronous serial line, idle high
//   RxAck    consumer acknowledge, clears RxValid and Overrun
//   RxData   last correctly framed byte, LSB first on the line
//   RxValid  high while RxData holds an unacknowledged byte
//   FrameErr high after a frame whose stop bit sampled low
//   Overrun  sticky, a good frame completed while RxValid was high
//   Busy     receiver is inside a frame
interface uart_rx_if #(parameter int DATA_BITS = 8);
    logic                 Tick;
    logic                 Rx;
    logic                 RxAck;
    logic [DATA_BITS-1:0] RxData;
    logic                 RxValid;
    logic                 FrameErr;
    logic                 Overrun;
    logic                 Busy;
    modport slave  (input Tick, Rx, RxAck, output RxData, RxValid, FrameErr, Overrun, Busy);
    modport master (output Tick, Rx, RxAck, input RxData, RxValid, FrameErr, Overrun, Busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, N data bits, one stop bit, no parity.
//   Clk    system clock, rising edge
//   Rst_n  asynchronous active-low reset
//   bus    uart_rx_if slave: Tick/Rx/RxAck in, RxData/RxValid/FrameErr/Overrun/Busy out
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input logic     Clk,
    input logic     Rst_n,
    uart_rx_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t               state, state_nxt;
    logic                 rx_m, rx_s;
    logic [3:0]           tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg, rx_data;
    logic                 rx_valid, frame_err, overrun;
    logic                 mid, full, last, good, bad;

    assign mid  = state == START && bus.Tick && tick_cnt == 4'(OVERSAMPLE/2 - 1);
    assign full = bus.Tick && tick_cnt == 4'(OVERSAMPLE - 1);
    assign last = bit_cnt == 3'(DATA_BITS - 1);
    assign good = state == STOP && full && rx_s;
    assign bad  = state == STOP && full && !rx_s;

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n)
            state <= IDLE;
        else
            state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!rx_s) state_nxt = START;
            START:   if (mid) state_nxt = rx_s ? IDLE : DATA;
            DATA:    if (full && last) state_nxt = STOP;
            default: if (full) state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.RxData   = rx_data;
        bus.RxValid  = rx_valid;
        bus.FrameErr = frame_err;
        bus.Overrun  = overrun;
        bus.Busy     = state != IDLE;
    end

    // Every terminal count clears tick_cnt, so it never wraps inside a state.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_m      <= bus.Rx;
            rx_s      <= rx_m;
            tick_cnt  <= (state == IDLE || mid || full) ? 4'd0 : tick_cnt + {3'd0, bus.Tick};
            bit_cnt   <= state != DATA ? 3'd0 : bit_cnt + {2'd0, full};
            shift_reg <= (state == DATA && full) ? {rx_s, shift_reg[DATA_BITS-1:1]} : shift_reg;
            // A completion coinciding with RxAck replaces the byte instead of overrunning.
            rx_data   <= (good && (!rx_valid || bus.RxAck)) ? shift_reg : rx_data;
            rx_valid  <= good ? 1'b1 : bus.RxAck ? 1'b0 : rx_valid;
            overrun   <= (good && rx_valid && !bus.RxAck) ? 1'b1 : bus.RxAck ? 1'b0 : overrun;
            frame_err <= good ? 1'b0 : bad ? 1'b1 : frame_err;
        end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx, Tick every 4 Clk, 16x oversample, 8N1 frames.
module tb_uart_rx;
    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] exp_q[$];
    logic       pv;
    logic [7:0] pd;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .bus  (bus)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        bus.Rx = 1'b0;
        repeat (64) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            bus.Rx = d[i];
            repeat (64) @(negedge Clk);
        end
        bus.Rx = stop_bit;
        repeat (stop_bit ? 64 : 44) @(negedge Clk);
        bus.Rx = 1'b1;
        repeat (100) @(negedge Clk);
    endtask

    task automatic ack_pulse();
        bus.RxAck = 1'b1;
        @(negedge Clk);
        bus.RxAck = 1'b0;
    endtask

    // 8 ticks in START, 128 in DATA, 16 in STOP: the 152nd busy tick is the stop sample.
    task automatic ack_at_stop();
        int n = 0;
        for (int k = 0; k < 2000 && n < 152; k++) begin
            @(negedge Clk);
            #1;
            if (bus.Busy && bus.Tick) n++;
            if (n == 152) begin
                bus.RxAck = 1'b1;
                @(negedge Clk);
                bus.RxAck = 1'b0;
            end
        end
        check("ack_stop_found", n, 152);
    endtask

    initial begin
        bus.Tick = 1'b0;
        forever begin
            repeat (3) @(negedge Clk);
            bus.Tick = 1'b1;
            @(negedge Clk);
            bus.Tick = 1'b0;
        end
    end

    initial begin
        pv = 1'b0;
        pd = '0;
        forever begin
            @(negedge Clk);
            if (Rst_n && ((bus.RxValid && !pv) || bus.RxData != pd)) begin
                check("sb_pending", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("sb_data", bus.RxData, exp_q.pop_front());
            end
            pv = bus.RxValid;
            pd = bus.RxData;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.Rx = 1'b1;
        bus.RxAck = 1'b0;
        repeat (4) @(negedge Clk);
        check("rst_data", bus.RxData, 0);
        check("rst_valid", bus.RxValid, 0);
        check("rst_ferr", bus.FrameErr, 0);
        check("rst_ovr", bus.Overrun, 0);
        check("rst_busy", bus.Busy, 0);
        Rst_n = 1'b1;
        repeat (20) @(negedge Clk);

        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        check("a5_data", bus.RxData, 8'hA5);
        check("a5_valid", bus.RxValid, 1);
        check("a5_ferr", bus.FrameErr, 0);
        check("a5_ovr", bus.Overrun, 0);
        ack_pulse();
        check("a5_ack_valid", bus.RxValid, 0);

        bus.Rx = 1'b0;
        repeat (8) @(negedge Clk);
        check("glitch_busy_hi", bus.Busy, 1);
        repeat (4) @(negedge Clk);
        bus.Rx = 1'b1;
        repeat (60) @(negedge Clk);
        check("glitch_busy_lo", bus.Busy, 0);
        check("glitch_valid", bus.RxValid, 0);

        send_frame(8'h3C, 1'b0);
        check("ferr_set", bus.FrameErr, 1);
        check("ferr_valid", bus.RxValid, 0);
        check("ferr_data", bus.RxData, 8'hA5);
        check("ferr_busy", bus.Busy, 0);
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        check("ferr_clr", bus.FrameErr, 0);
        check("x11_data", bus.RxData, 8'h11);
        check("x11_valid", bus.RxValid, 1);
        ack_pulse();

        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        check("ovr_data", bus.RxData, 8'h01);
        check("ovr_set", bus.Overrun, 1);
        check("ovr_valid", bus.RxValid, 1);
        ack_pulse();
        check("ovr_clr", bus.Overrun, 0);
        check("ovr_valid_clr", bus.RxValid, 0);

        exp_q.push_back(8'h05);
        send_frame(8'h05, 1'b1);
        exp_q.push_back(8'h02);
        fork
            send_frame(8'h02, 1'b1);
            ack_at_stop();
        join
        check("ackstop_data", bus.RxData, 8'h02);
        check("ackstop_valid", bus.RxValid, 1);
        check("ackstop_ovr", bus.Overrun, 0);

        bus.Rx = 1'b0;
        repeat (64) @(negedge Clk);
        for (int i = 0; i < 4; i++) begin
            bus.Rx = i[0];
            repeat (64) @(negedge Clk);
        end
        bus.Rx = 1'b1;
        repeat (32) @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        check("mrst_data", bus.RxData, 0);
        check("mrst_valid", bus.RxValid, 0);
        check("mrst_ferr", bus.FrameErr, 0);
        check("mrst_ovr", bus.Overrun, 0);
        check("mrst_busy", bus.Busy, 0);
        repeat (3) @(negedge Clk);
        Rst_n = 1'b1;
        repeat (80) @(negedge Clk);
        check("mrst_idle_valid", bus.RxValid, 0);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        check("x7e_data", bus.RxData, 8'h7E);
        check("x7e_valid", bus.RxValid, 1);
        check("x7e_ferr", bus.FrameErr, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
